sgbm_frame_timing: RTL and testbench

SGBM_FRAME_TIMING -- requirements
Module: sgbm_frame_timing

---
 rtl/sgbm_frame_timing.sv | 216 +++++++++++++++++++++
 tb/tb_sgbm_frame_timing.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgbm_frame_timing.sv
// sgbm_frame_timing
//   Raster timing generator for the SGBM pipeline. On a start request it
//   walks an IMG_W x IMG_H frame pixel by pixel, honouring a valid/ready
//   handshake with the downstream stage. It inserts H_BLANK idle cycles
//   between lines and V_BLANK idle cycles after the last line, then returns
//   to IDLE. All outputs come straight from flops.
//
// Parameters
//   IMG_W    active pixels per line (1..2048)
//   IMG_H    active lines per frame (1..2048)
//   H_BLANK  idle cycles between lines (0..255)
//   V_BLANK  idle cycles after the last line (0..255)
//
// Ports
//   clkin        sole clock (divided SGBM pipeline clock)
//   rst0         asynchronous active-high reset
//   start        frame request, only looked at while idle
//   pix_ready    downstream accepts the presented pixel
//   pix_valid    x/y and the qualifiers describe a pixel
//   x, y         pixel column / row
//   line_start   first pixel of a line
//   frame_start  first pixel of the frame
//   frame_end    last pixel of the frame
//   busy         frame in progress (including vertical blanking)
//   frame_cnt    (only with SGBM_FRAME_CNT_EN) completed-frame counter
//
// Build option
//   SGBM_FRAME_CNT_EN  adds the 16-bit frame_cnt output. It counts transfers
//                      of the frame_end pixel and wraps modulo 2^16.

module sgbm_frame_timing #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 4
) (
  input  logic        clkin,
  input  logic        rst0,
  input  logic        start,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        frame_end,
  output logic        busy
`ifdef SGBM_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [10:0] X_LAST = 11'(IMG_W - 1);
  localparam logic [10:0] Y_LAST = 11'(IMG_H - 1);
  // Blank counters are loaded with length-1 and count down to zero. A zero
  // length never loads the counter, so the value 0 is simply unused then.
  localparam logic [7:0]  H_LOAD = 8'((H_BLANK > 0) ? (H_BLANK - 1) : 0);
  localparam logic [7:0]  V_LOAD = 8'((V_BLANK > 0) ? (V_BLANK - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  blank_cnt, blank_nxt;
  logic [10:0] x_nxt, y_nxt, x_inc, y_inc;
  logic        valid_nxt, ls_nxt, fs_nxt, fe_nxt, busy_nxt;
  logic        xfer;

  assign xfer  = (state == ACTIVE) && pix_valid && pix_ready;
  assign x_inc = x + 11'd1;
  assign y_inc = y + 11'd1;

  // State and output registers. Every output is a flop, so the reset
  // values appear as soon as rst0 rises.
  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      state       <= IDLE;
      blank_cnt   <= 8'd0;
      pix_valid   <= 1'b0;
      x           <= 11'd0;
      y           <= 11'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      blank_cnt   <= blank_nxt;
      pix_valid   <= valid_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      frame_end   <= fe_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state and next-output logic. Holding every register by default
  // makes a stalled pixel (pix_ready=0) keep all of its fields unchanged.
  always_comb begin
    state_nxt = state;
    blank_nxt = blank_cnt;
    valid_nxt = pix_valid;
    x_nxt     = x;
    y_nxt     = y;
    ls_nxt    = line_start;
    fs_nxt    = frame_start;
    fe_nxt    = frame_end;
    busy_nxt  = busy;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACTIVE;
          valid_nxt = 1'b1;
          x_nxt     = 11'd0;
          y_nxt     = 11'd0;
          ls_nxt    = 1'b1;
          fs_nxt    = 1'b1;
          fe_nxt    = (X_LAST == 11'd0) && (Y_LAST == 11'd0);
          busy_nxt  = 1'b1;
        end
      end

      ACTIVE: begin
        if (xfer) begin
          if (x != X_LAST) begin
            x_nxt  = x_inc;
            ls_nxt = 1'b0;
            fs_nxt = 1'b0;
            fe_nxt = (x_inc == X_LAST) && (y == Y_LAST);
          end else if (y != Y_LAST) begin
            // End of a line that is not the last one.
            if (H_BLANK == 0) begin
              x_nxt  = 11'd0;
              y_nxt  = y_inc;
              ls_nxt = 1'b1;
              fs_nxt = 1'b0;
              fe_nxt = (X_LAST == 11'd0) && (y_inc == Y_LAST);
            end else begin
              state_nxt = HBLANK;
              blank_nxt = H_LOAD;
              valid_nxt = 1'b0;
              ls_nxt    = 1'b0;
              fs_nxt    = 1'b0;
              fe_nxt    = 1'b0;
            end
          end else begin
            // The frame_end pixel has been accepted.
            valid_nxt = 1'b0;
            x_nxt     = 11'd0;
            y_nxt     = 11'd0;
            ls_nxt    = 1'b0;
            fs_nxt    = 1'b0;
            fe_nxt    = 1'b0;
            if (V_BLANK == 0) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
            end else begin
              state_nxt = VBLANK;
              blank_nxt = V_LOAD;
            end
          end
        end
      end

      HBLANK: begin
        if (blank_cnt == 8'd0) begin
          state_nxt = ACTIVE;
          valid_nxt = 1'b1;
          x_nxt     = 11'd0;
          y_nxt     = y_inc;
          ls_nxt    = 1'b1;
          fs_nxt    = 1'b0;
          fe_nxt    = (X_LAST == 11'd0) && (y_inc == Y_LAST);
        end else begin
          blank_nxt = blank_cnt - 8'd1;
        end
      end

      VBLANK: begin
        // Always passes through IDLE, so a held start waits one idle cycle.
        if (blank_cnt == 8'd0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          blank_nxt = blank_cnt - 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

`ifdef SGBM_FRAME_CNT_EN
  // Counts accepted frame_end pixels. An aborted frame never reaches one.
  always_ff @(posedge clkin or posedge rst0) begin
    if (rst0) begin
      frame_cnt <= 16'd0;
    end else if (xfer && frame_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sgbm_frame_timing.sv
// tb_sgbm_frame_timing
//   Directed bench for sgbm_frame_timing. The main instance uses
//   IMG_W=4, IMG_H=2, H_BLANK=2, V_BLANK=3. Two side instances cover the
//   corner cases: H_BLANK=0, and a 1x1 frame with no blanking.
//   Outputs are sampled 1 time unit after each rising clkin edge.

module tb_sgbm_frame_timing;

  logic clkin = 1'b0;
  logic rst0, start, pix_ready, start_b, ready_b;

  logic        pv_m, ls_m, fs_m, fe_m, busy_m;
  logic [10:0] x_m, y_m;
  logic        pv_h, ls_h, fs_h, fe_h, busy_h;
  logic [10:0] x_h, y_h;
  logic        pv_w, ls_w, fs_w, fe_w, busy_w;
  logic [10:0] x_w, y_w;
`ifdef SGBM_FRAME_CNT_EN
  logic [15:0] frame_cnt_m, frame_cnt_h, frame_cnt_w;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clkin = ~clkin;

  // Main instance.
  sgbm_frame_timing #(.IMG_W(4), .IMG_H(2), .H_BLANK(2), .V_BLANK(3)) dut (
    .clkin(clkin), .rst0(rst0), .start(start), .pix_ready(pix_ready),
    .pix_valid(pv_m), .x(x_m), .y(y_m), .line_start(ls_m),
    .frame_start(fs_m), .frame_end(fe_m), .busy(busy_m)
`ifdef SGBM_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_m)
`endif
  );

  // Side instance with no horizontal blanking.
  sgbm_frame_timing #(.IMG_W(4), .IMG_H(2), .H_BLANK(0), .V_BLANK(3)) dut_hb0 (
    .clkin(clkin), .rst0(rst0), .start(start_b), .pix_ready(ready_b),
    .pix_valid(pv_h), .x(x_h), .y(y_h), .line_start(ls_h),
    .frame_start(fs_h), .frame_end(fe_h), .busy(busy_h)
`ifdef SGBM_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_h)
`endif
  );

  // Side instance with a single-pixel frame.
  sgbm_frame_timing #(.IMG_W(1), .IMG_H(1), .H_BLANK(0), .V_BLANK(0)) dut_w1 (
    .clkin(clkin), .rst0(rst0), .start(start_b), .pix_ready(ready_b),
    .pix_valid(pv_w), .x(x_w), .y(y_w), .line_start(ls_w),
    .frame_start(fs_w), .frame_end(fe_w), .busy(busy_w)
`ifdef SGBM_FRAME_CNT_EN
    , .frame_cnt(frame_cnt_w)
`endif
  );

  // Packed view {valid, busy, ls, fs, fe, x, y}. Pixel fields are masked
  // while no pixel is presented.
  function automatic logic [31:0] mk(input logic v, b, ls, fs, fe,
                                     input logic [10:0] px, py);
    if (v) return {5'd0, 1'b1, b, ls, fs, fe, px, py};
    return {5'd0, 1'b0, b, 25'd0};
  endfunction

  function automatic logic [31:0] raw(input logic v, b, ls, fs, fe,
                                      input logic [10:0] px, py);
    return {5'd0, v, b, ls, fs, fe, px, py};
  endfunction

  function automatic logic [31:0] pix(input logic ls, fs, fe, input int px, py);
    return {5'd0, 1'b1, 1'b1, ls, fs, fe, 11'(px), 11'(py)};
  endfunction

  function automatic logic [31:0] idl(input logic b);
    return {5'd0, 1'b0, b, 25'd0};
  endfunction

  function automatic logic [31:0] obs_m();
    return mk(pv_m, busy_m, ls_m, fs_m, fe_m, x_m, y_m);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start     = s;
    pix_ready = r;
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic runToIdle(input string tag);
    for (int i = 0; i < 200 && busy_m; i++) tick();
    checkOutput(tag, {31'd0, busy_m}, 32'd0);
  endtask

  logic [31:0] exp_f1 [15];
  logic [31:0] exp_hb [6];
  int          xfers;

  initial begin
    rst0 = 1'b0; start = 1'b0; pix_ready = 1'b0;
    start_b = 1'b0; ready_b = 1'b1;

    // Reset is asynchronous: check before the first clock edge.
    #2 rst0 = 1'b1;
    #1;
    checkOutput("reset_async", raw(pv_m, busy_m, ls_m, fs_m, fe_m, x_m, y_m), 32'd0);
`ifdef SGBM_FRAME_CNT_EN
    checkOutput("reset_frame_cnt", {16'd0, frame_cnt_m}, 32'd0);
`endif
    @(posedge clkin);
    @(posedge clkin);
    @(negedge clkin);
    rst0 = 1'b0;
    tick();
    checkOutput("idle_after_reset", obs_m(), idl(1'b0));

    // Side instances: H_BLANK=0 and the 1x1 frame.
    exp_hb[0] = pix(1, 1, 0, 0, 0);
    exp_hb[1] = pix(0, 0, 0, 1, 0);
    exp_hb[2] = pix(0, 0, 0, 2, 0);
    exp_hb[3] = pix(0, 0, 0, 3, 0);
    exp_hb[4] = pix(1, 0, 0, 0, 1);
    exp_hb[5] = pix(0, 0, 0, 1, 1);
    start_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      start_b = 1'b0;
      checkOutput($sformatf("hb0_c%0d", k), mk(pv_h, busy_h, ls_h, fs_h, fe_h, x_h, y_h), exp_hb[k]);
      if (k == 0)
        checkOutput("w1_pixel", mk(pv_w, busy_w, ls_w, fs_w, fe_w, x_w, y_w), pix(1, 1, 1, 0, 0));
      if (k == 1)
        checkOutput("w1_done", mk(pv_w, busy_w, ls_w, fs_w, fe_w, x_w, y_w), idl(1'b0));
    end
    for (int k = 0; k < 10; k++) tick();
    checkOutput("hb0_done", mk(pv_h, busy_h, ls_h, fs_h, fe_h, x_h, y_h), idl(1'b0));
    checkOutput("main_untouched", obs_m(), idl(1'b0));
`ifdef SGBM_FRAME_CNT_EN
    checkOutput("hb0_frame_cnt", {16'd0, frame_cnt_h}, 32'd1);
    checkOutput("w1_frame_cnt", {16'd0, frame_cnt_w}, 32'd1);
`endif

    // Full frame, pix_ready=1. A start pulse mid-frame is ignored; start
    // is then held high across the end of the frame.
    exp_f1[0]  = pix(1, 1, 0, 0, 0);
    exp_f1[1]  = pix(0, 0, 0, 1, 0);
    exp_f1[2]  = pix(0, 0, 0, 2, 0);
    exp_f1[3]  = pix(0, 0, 0, 3, 0);
    exp_f1[4]  = idl(1'b1);
    exp_f1[5]  = idl(1'b1);
    exp_f1[6]  = pix(1, 0, 0, 0, 1);
    exp_f1[7]  = pix(0, 0, 0, 1, 1);
    exp_f1[8]  = pix(0, 0, 0, 2, 1);
    exp_f1[9]  = pix(0, 0, 1, 3, 1);
    exp_f1[10] = idl(1'b1);
    exp_f1[11] = idl(1'b1);
    exp_f1[12] = idl(1'b1);
    exp_f1[13] = idl(1'b0);
    exp_f1[14] = pix(1, 1, 0, 0, 0);
    xfers = 0;
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (k <= 9 && pv_m && pix_ready) xfers++;
      checkOutput($sformatf("frame1_c%0d", k), obs_m(), exp_f1[k]);
`ifdef SGBM_FRAME_CNT_EN
      if (k == 13) checkOutput("frame_cnt_after_f1", {16'd0, frame_cnt_m}, 32'd1);
`endif
      applyStimulus((k == 4) || (k >= 9 && k < 14), 1'b1);
    end
    checkOutput("transfer_count", 32'(xfers), 32'd8);

    // Second frame: stall three cycles while presenting (2,0).
    tick();
    checkOutput("stall_pre1", obs_m(), pix(0, 0, 0, 1, 0));
    tick();
    checkOutput("stall_pre2", obs_m(), pix(0, 0, 0, 2, 0));
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("stall_hold%0d", k), obs_m(), pix(0, 0, 0, 2, 0));
    end
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("stall_release", obs_m(), pix(0, 0, 0, 3, 0));
    tick();
    checkOutput("hblank_a", obs_m(), idl(1'b1));
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("hblank_b", obs_m(), idl(1'b1));
    tick();
    checkOutput("line1_start", obs_m(), pix(1, 0, 0, 0, 1));
    tick();
    checkOutput("line1_stall", obs_m(), pix(1, 0, 0, 0, 1));
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("at_pixel_1_1", obs_m(), pix(0, 0, 0, 1, 1));

    // Abort mid-frame with an asynchronous reset.
    #2 rst0 = 1'b1;
    #1;
    checkOutput("abort_async", raw(pv_m, busy_m, ls_m, fs_m, fe_m, x_m, y_m), 32'd0);
`ifdef SGBM_FRAME_CNT_EN
    checkOutput("abort_frame_cnt", {16'd0, frame_cnt_m}, 32'd0);
`endif
    tick();
    checkOutput("abort_hold", raw(pv_m, busy_m, ls_m, fs_m, fe_m, x_m, y_m), 32'd0);
    #3 rst0 = 1'b0;
    tick();
    checkOutput("abort_idle", obs_m(), idl(1'b0));
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart_origin", obs_m(), pix(1, 1, 0, 0, 0));

    // Two complete frames after the reset.
    runToIdle("frame_a_done");
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1);
    checkOutput("frame_b_start", obs_m(), pix(1, 1, 0, 0, 0));
    runToIdle("frame_b_done");
`ifdef SGBM_FRAME_CNT_EN
    checkOutput("frame_cnt_two", {16'd0, frame_cnt_m}, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
